mem1r1w_port_driver: RTL

Initiator-side driver for the one-read/one-write memory helper port (`r_0_*` / `w_0_*`). It accepts a single valid/ready request stream of reads and masked writes and issues each request to the memory port as a one-cycle pulse. It handles both synchronous and asynchronous read timing, selected by `r_0_async`, and returns read data in order through a credit-protected response FIFO. It sits between a core-side agent or test driver and a `Mem1R1WHelper`-style memory model.

---
 rtl/mem1r1w_port_driver.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem1r1w_port_driver.sv
// Initiator-side driver for a one-read/one-write memory port: registers each request
// into a one-cycle strobe and returns read data in order through a credit-protected FIFO.
`timescale 1ns/1ps
module mem1r1w_port_driver #(
  parameter int INDEX_WIDTH = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int RESP_DEPTH  = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [INDEX_WIDTH-1:0] req_index,
  input  logic [DATA_WIDTH-1:0]  req_data,
  input  logic [DATA_WIDTH-1:0]  req_mask,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [DATA_WIDTH-1:0]  resp_data,
  output logic                   r_0_enable,
  output logic [INDEX_WIDTH-1:0] r_0_index,
  input  logic [DATA_WIDTH-1:0]  r_0_data,
  input  logic                   r_0_async,
  output logic                   w_0_enable,
  output logic [INDEX_WIDTH-1:0] w_0_index,
  output logic [DATA_WIDTH-1:0]  w_0_data,
  output logic [DATA_WIDTH-1:0]  w_0_mask
);

  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  logic                   r_en_q, r_en_d;
  logic [INDEX_WIDTH-1:0] r_idx_q, r_idx_d;
  logic                   w_en_q, w_en_d;
  logic [INDEX_WIDTH-1:0] w_idx_q, w_idx_d;
  logic [DATA_WIDTH-1:0]  w_data_q, w_data_d;
  logic [DATA_WIDTH-1:0]  w_mask_q, w_mask_d;
  logic                   pend_q, pend_d;
  logic [1:0]             inflight_q, inflight_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [DATA_WIDTH-1:0]  fifo_q [RESP_DEPTH];
  logic [DATA_WIDTH-1:0]  fifo_d [RESP_DEPTH];

  logic accept;
  logic rd_accept;
  logic push;
  logic pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credits cover both buffered and in-flight reads, so a capture always finds a free slot.
  assign req_ready  = !reset && ((int'(count_q) + int'(inflight_q)) < RESP_DEPTH);
  assign accept     = req_valid && req_ready;
  assign rd_accept  = accept && !req_write;
  assign push       = pend_q || (r_en_q && r_0_async);
  assign resp_valid = (count_q != '0);
  assign pop        = resp_valid && resp_ready;
  assign resp_data  = fifo_q[head_q];

  assign r_0_enable = r_en_q;
  assign r_0_index  = r_idx_q;
  assign w_0_enable = w_en_q;
  assign w_0_index  = w_idx_q;
  assign w_0_data   = w_data_q;
  assign w_0_mask   = w_mask_q;

  always_comb begin
    r_en_d   = 1'b0;
    w_en_d   = 1'b0;
    r_idx_d  = r_idx_q;
    w_idx_d  = w_idx_q;
    w_data_d = w_data_q;
    w_mask_d = w_mask_q;
    if (accept) begin
      if (req_write) begin
        w_en_d   = 1'b1;
        w_idx_d  = req_index;
        w_data_d = req_data;
        w_mask_d = req_mask;
      end else begin
        r_en_d  = 1'b1;
        r_idx_d = req_index;
      end
    end
  end

  always_comb begin
    pend_d     = r_en_q && !r_0_async;
    inflight_d = inflight_q + 2'(rd_accept) - 2'(push);
    head_d     = pop  ? ptr_inc(head_q) : head_q;
    tail_d     = push ? ptr_inc(tail_q) : tail_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    fifo_d = fifo_q;
    if (push) begin
      fifo_d[tail_q] = r_0_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_en_q     <= 1'b0;
      r_idx_q    <= '0;
      w_en_q     <= 1'b0;
      w_idx_q    <= '0;
      w_data_q   <= '0;
      w_mask_q   <= '0;
      pend_q     <= 1'b0;
      inflight_q <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      r_en_q     <= r_en_d;
      r_idx_q    <= r_idx_d;
      w_en_q     <= w_en_d;
      w_idx_q    <= w_idx_d;
      w_data_q   <= w_data_d;
      w_mask_q   <= w_mask_d;
      pend_q     <= pend_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < RESP_DEPTH; gi++) begin : g_fifo
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          fifo_q[gi] <= '0;
        end else begin
          fifo_q[gi] <= fifo_d[gi];
        end
      end
    end
  endgenerate

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(push && !pop && (count_q == CNT_W'(RESP_DEPTH))));
  a_one_strobe: assert property (@(posedge clock) disable iff (reset)
    !(r_en_q && w_en_q));
  // A sync read capturing while an async read strobes would need r_0_data twice in one cycle.
  a_no_capture_clash: assert property (@(posedge clock) disable iff (reset)
    !(pend_q && r_en_q && r_0_async));

endmodule
